// File: rtl/dac_voice_mixer_sched_pkg.sv
// Shared types and constants for the DAC voice mixer scheduler.
// Optional dither (build macro MIX_DITHER_EN) uses the LFSR constants below.
package dac_voice_mixer_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        CLIP = 2'd2
    } mix_state_t;

    // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Offset-binary code for a zero-valued sample
    function automatic int unsigned midscale_code(input int unsigned dac_w);
        return 32'd1 << (dac_w - 1);
    endfunction

    // Enough headroom that the sum of all voices cannot wrap before saturation
    function automatic int unsigned acc_width(input int unsigned sample_w,
                                              input int unsigned num_voices);
        return sample_w + $clog2(num_voices);
    endfunction

endpackage

// File: rtl/dac_voice_mixer_sched_prescaler.sv
// Sample-rate prescaler: free-running 0..TICK_DIV-1 counter, tick on the last count.
module mix_tick_prescaler #(
    parameter int TICK_DIV = 1024
) (
    input  logic i_clk,
    input  logic i_res,
    output logic o_tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Wrapping period counter
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_res) begin
            cnt <= '0;
        end else if (cnt == LAST_CNT) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_tick = (cnt == LAST_CNT);

endmodule

// File: rtl/dac_voice_mixer_sched.sv
// Time-division mixer feeding one delta-sigma DAC from NUM_VOICES tone voices.
// Each tick: scan voices with valid/ack, sum with saturation, convert to
// offset binary, hold the top DAC_W bits until the next sweep.
// Build macro MIX_DITHER_EN adds LFSR dither before truncation.
module dac_voice_mixer_sched
    import dac_voice_mixer_sched_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_W   = 8,
    parameter int DAC_W      = 6,
    parameter int TICK_DIV   = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_res,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] i_voice_data,
    input  logic [NUM_VOICES-1:0]          i_voice_valid,
    output logic [NUM_VOICES-1:0]          o_voice_ack,
    input  logic                           i_mute,
    output logic [DAC_W-1:0]               o_dac_data,
    output logic                           o_tick,
    output logic                           o_busy
);

    localparam int ACC_W = int'(acc_width(SAMPLE_W, NUM_VOICES));
    localparam int IDX_W = $clog2(NUM_VOICES);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NUM_VOICES - 1);
    localparam logic [DAC_W-1:0]        MIDSCALE = DAC_W'(midscale_code(DAC_W));
    localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << (SAMPLE_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

    mix_state_t                 state;
    logic signed [ACC_W-1:0]    acc;
    logic [IDX_W-1:0]           idx;
    logic [SAMPLE_W-1:0]        voice_samples [NUM_VOICES];
    logic [SAMPLE_W-1:0]        cur_sample;
    logic [ACC_W-1:0]           sample_ext;
    logic [SAMPLE_W-1:0]        sat_val;
    logic [SAMPLE_W-1:0]        off_val;
    logic [SAMPLE_W-1:0]        mix_val;
    logic [DAC_W-1:0]           code;

    mix_tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .i_clk  (i_clk),
        .i_res  (i_res),
        .o_tick (o_tick)
    );

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_unpack
        assign voice_samples[v] = i_voice_data[v*SAMPLE_W +: SAMPLE_W];
    end

    assign cur_sample = voice_samples[idx];
    assign sample_ext = {{(ACC_W - SAMPLE_W){cur_sample[SAMPLE_W-1]}}, cur_sample};

    // Handshake: ack the scanned voice in the same cycle its sample is taken
    always_comb begin
        // NOTE: default assignment first so no path leaves the output
        // unassigned and a latch cannot be inferred.
        o_voice_ack = '0;
        if (!i_res && state == SCAN && i_voice_valid[idx]) begin
            o_voice_ack[idx] = 1'b1;
        end
    end

    // Saturate to sample range, then flip MSB to move to offset binary
    always_comb begin
        if (acc > SAT_MAX) begin
            sat_val = SAT_MAX[SAMPLE_W-1:0];
        end else if (acc < SAT_MIN) begin
            sat_val = SAT_MIN[SAMPLE_W-1:0];
        end else begin
            sat_val = acc[SAMPLE_W-1:0];
        end
        off_val = {~sat_val[SAMPLE_W-1], sat_val[SAMPLE_W-2:0]};
    end

`ifdef MIX_DITHER_EN
    logic [15:0] lfsr;

    // Dither source advances once per sample period
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            lfsr <= LFSR_SEED;
        end else if (o_tick) begin
            lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
        end
    end

    if (SAMPLE_W > DAC_W) begin : g_dither
        logic [SAMPLE_W:0] dith_sum;
        assign dith_sum = {1'b0, off_val} + (SAMPLE_W + 1)'(lfsr[SAMPLE_W-DAC_W-1:0]);
        // Clamp at all-ones instead of wrapping to a low code
        assign mix_val  = dith_sum[SAMPLE_W] ? '1 : dith_sum[SAMPLE_W-1:0];
    end else begin : g_no_dither
        assign mix_val = off_val;
    end
`else
    assign mix_val = off_val;
`endif

    assign code = DAC_W'(mix_val >> (SAMPLE_W - DAC_W));

    // Sweep sequencer: IDLE waits for tick, SCAN one voice per cycle, CLIP loads DAC
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            state      <= IDLE;
            acc        <= '0;
            idx        <= '0;
            o_busy     <= 1'b0;
            o_dac_data <= MIDSCALE;
        end else begin
            case (state)
                IDLE: begin
                    if (o_tick) begin
                        state  <= SCAN;
                        acc    <= '0;
                        idx    <= '0;
                        o_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (i_voice_valid[idx]) begin
                        acc <= acc + sample_ext;
                    end
                    if (idx == LAST_IDX) begin
                        state <= CLIP;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                CLIP: begin
                    o_dac_data <= i_mute ? MIDSCALE : code;
                    state      <= IDLE;
                    o_busy     <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dac_voice_mixer_sched.md
Name: dac_voice_mixer_sched

Overview:
Time-division scheduler that shares the single delta-sigma DAC input between NUM_VOICES MIDI tone voices. A sample-rate prescaler fires once every TICK_DIV clocks. On each tick the block scans every voice in turn, accepts its sample through a valid/ack handshake, and sums the samples with saturation. It then converts the sum to offset-binary DAC_W bits and holds the result on the DAC data input until the next tick.

Parameters:
- NUM_VOICES, 4: number of voice requesters; must be 2 or more.
- SAMPLE_W, 8: width of each voice sample, signed two's complement.
- DAC_W, 6: width of the DAC input code; must be less than or equal to SAMPLE_W.
- TICK_DIV, 1024: clocks per sample period; must be greater than NUM_VOICES+3.

Ports:
- i_clk  in  1  system clock.
- i_res  in  1  synchronous reset, active-high.
- i_voice_data  in  NUM_VOICES*SAMPLE_W  packed voice samples; voice v occupies bits [v*SAMPLE_W +: SAMPLE_W].
- i_voice_valid  in  NUM_VOICES  voice v has a sample pending.
- o_voice_ack  out  NUM_VOICES  one-cycle pulse: the sample of voice v was consumed this cycle.
- i_mute  in  1  force the midscale output code.
- o_dac_data  out  DAC_W  unsigned code to the DAC; registered.
- o_tick  out  1  one-cycle pulse at the start of each sample period.
- o_busy  out  1  high while the FSM is not in IDLE.

Behaviour:
Reset, when i_res is high at a clock edge:
- Prescaler counter = 0, FSM = IDLE, accumulator = 0, scan index = 0.
- o_voice_ack = 0, o_tick = 0, o_busy = 0.
- o_dac_data = 2^(DAC_W-1) (midscale; 32 at default parameters).
- Reset during SCAN or CLIP aborts the sweep. No ack is issued in the reset cycle. o_dac_data returns to midscale.

Prescaler:
- Counter runs 0 to TICK_DIV-1 and wraps.
- o_tick = 1 in the cycle the counter equals TICK_DIV-1.
- The counter runs freely in every FSM state.

FSM states:
- IDLE to SCAN when o_tick = 1. Accumulator cleared and index set to 0 on this transition.
- SCAN lasts one cycle per voice, v = 0 to NUM_VOICES-1.
  - If i_voice_valid[v] = 1: accumulator += sign-extended sample of voice v, and o_voice_ack[v] = 1 in that same cycle.
  - If i_voice_valid[v] = 0: the voice contributes 0 and gets no ack.
  - At most one ack bit is high in any cycle.
- SCAN to CLIP after v = NUM_VOICES-1.
- CLIP, one cycle:
  - Saturate the accumulator to the range [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
  - Add 2^(SAMPLE_W-1) to convert to offset binary.
  - Take the top DAC_W bits.
  - Register the result into o_dac_data at the CLIP-to-IDLE edge.
  - If i_mute = 1 during CLIP, load midscale instead.
- CLIP to IDLE unconditionally.

Width rules:
- Accumulator width is SAMPLE_W + clog2(NUM_VOICES), so the sum never overflows before saturation.

Latency:
- Tick in cycle T.
- SCAN in cycles T+1 to T+NUM_VOICES.
- CLIP in cycle T+NUM_VOICES+1.
- New o_dac_data visible from cycle T+NUM_VOICES+2.

Boundary conditions:
- A voice that drops valid during its own scan slot is treated as absent.
- Valid asserted after a voice's slot has passed waits for the next tick.
- o_dac_data never changes outside the CLIP-to-IDLE edge, except on reset.
- All voices invalid gives midscale.
- A change of i_mute takes effect only at the next CLIP.

Optional Feature:
Macro: MIX_DITHER_EN
- Defined:
  - A 16-bit Fibonacci LFSR with taps 16, 14, 13, 11 is seeded with 0xACE1 on reset.
  - The LFSR advances once per tick.
  - In CLIP, the low (SAMPLE_W-DAC_W) LFSR bits are added to the offset-binary value before truncation.
  - That addition saturates at all-ones.
  - Mute still forces exact midscale.
  - No effect when DAC_W = SAMPLE_W.
- Undefined: plain truncation and no LFSR logic. The test plan below assumes the macro is undefined.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, SCAN, CLIP).
  - Midscale constant function of DAC_W.
  - Accumulator-width function.
  - LFSR seed and tap constants.
- One sub-module is natural: mix_tick_prescaler, parameterised by TICK_DIV, producing the o_tick pulse.

Test Plan:
All scenarios use default parameters and MIX_DITHER_EN undefined.
- Hold i_res high for 3 cycles, then release -> o_dac_data = 32, o_busy = 0, acks = 0. The first o_tick occurs 1023 cycles after reset release, when the counter reaches 1023.
- Voice 0 valid with 20, other voices invalid, tick at cycle T -> ack[0] pulses at T+1, no other ack, o_dac_data = 37 from T+6.
- Voices 0 and 1 valid with 100 each -> sum 200 saturates to 127, o_dac_data = 63. Repeat with -100 each -> -128, o_dac_data = 0.
- All four voices valid (10, -10, 5, -5) with i_mute = 1 during CLIP -> all four acks pulse in consecutive cycles T+1 to T+4, o_dac_data = 32.
- Assert i_res during the SCAN cycle of voice 2, after a previous output of 63 -> no ack[2], o_dac_data = 32 immediately, FSM returns to IDLE, the next tick scans normally.
- Voice 3 raises valid during voice 1's slot -> ack[3] pulses at T+4 in the same sweep. Voice 0 raising valid at T+2 waits until the following tick.
